// File: rtl/fft_seq.sv
// fft_seq: control sequencer for a streaming FFT core (load frame, run stages, unload frame).
// Optional macro FFT_SEQ_CONTINUOUS_EN: the last output beat re-enters the load phase without a start.
module fft_seq #(
    parameter int LANES      = 4,
    parameter int NUMSAMPLES = 32,
    parameter int NUMSTAGES  = 5,
    parameter int TIMEOUT    = 255,
    localparam int BW = ((NUMSAMPLES / LANES) > 1) ? $clog2(NUMSAMPLES / LANES) : 1,
    localparam int SW = $clog2(NUMSTAGES + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic          ld_valid,
    output logic          ld_data,
    output logic          en,
    input  logic          stage_done,
    output logic [SW-1:0] stage,
    output logic          output_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [BW-1:0] beat,
    output logic          done,
    output logic          error
);

    typedef enum logic [2:0] {
        IDLE,
        LDRAM,
        RAMRDY,
        RUNNING,
        DONE,
        OUTPUT
    } state_e;

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [BW-1:0] LASTBEAT  = BW'((NUMSAMPLES / LANES) - 1);
    localparam logic [SW-1:0] LASTSTAGE = SW'(NUMSTAGES - 1);
    localparam logic [TW-1:0] IDLELIMIT = TW'(TIMEOUT - 1);

    state_e        state_q, state_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [SW-1:0] stage_q, stage_d;
    logic [TW-1:0] idle_q, idle_d;
    logic          error_q, error_d;
    logic          ld_data_q, ld_data_d;
    logic          en_q, en_d;
    logic          output_data_q, output_data_d;
    logic          out_valid_q, out_valid_d;
    logic          done_q, done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            beat_q        <= '0;
            stage_q       <= '0;
            idle_q        <= '0;
            error_q       <= 1'b0;
            ld_data_q     <= 1'b0;
            en_q          <= 1'b0;
            output_data_q <= 1'b0;
            out_valid_q   <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            beat_q        <= beat_d;
            stage_q       <= stage_d;
            idle_q        <= idle_d;
            error_q       <= error_d;
            ld_data_q     <= ld_data_d;
            en_q          <= en_d;
            output_data_q <= output_data_d;
            out_valid_q   <= out_valid_d;
            done_q        <= done_d;
        end
    end

    // Abort overrides every transition but leaves the sticky error flag alone.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        stage_d = stage_q;
        idle_d  = idle_q;
        error_d = error_q;
        if (abort) begin
            state_d = IDLE;
            beat_d  = '0;
            stage_d = '0;
            idle_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = LDRAM;
                        error_d = 1'b0;
                        beat_d  = '0;
                        idle_d  = '0;
                    end
                end
                LDRAM: begin
                    if (ld_valid) begin
                        idle_d = '0;
                        if (beat_q == LASTBEAT) begin
                            state_d = RAMRDY;
                            beat_d  = '0;
                        end else begin
                            beat_d = beat_q + BW'(1);
                        end
                    end else if (idle_q == IDLELIMIT) begin
                        state_d = IDLE;
                        error_d = 1'b1;
                        idle_d  = '0;
                        beat_d  = '0;
                    end else begin
                        idle_d = idle_q + TW'(1);
                    end
                end
                RAMRDY: state_d = RUNNING;
                RUNNING: begin
                    if (stage_done) begin
                        stage_d = stage_q + SW'(1);
                        if (stage_q == LASTSTAGE) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: state_d = OUTPUT;
                OUTPUT: begin
                    if (out_valid_q && out_ready) begin
                        if (beat_q == LASTBEAT) begin
                            beat_d  = '0;
                            stage_d = '0;
`ifdef FFT_SEQ_CONTINUOUS_EN
                            state_d = LDRAM;
                            idle_d  = '0;
`else
                            state_d = IDLE;
`endif
                        end else begin
                            beat_d = beat_q + BW'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Flags are decoded from the next state so they leave the flops aligned with it.
    always_comb begin
        ld_data_d     = (state_d == LDRAM);
        en_d          = (state_d == RUNNING);
        output_data_d = (state_d == OUTPUT);
        out_valid_d   = (state_d == OUTPUT);
        done_d        = (state_d == DONE) || (state_d == OUTPUT);
    end

    assign ld_data     = ld_data_q;
    assign en          = en_q;
    assign output_data = output_data_q;
    assign out_valid   = out_valid_q;
    assign done        = done_q;
    assign error       = error_q;
    assign stage       = stage_q;
    assign beat        = beat_q;

endmodule

// File: doc/fft_seq.md
FFT_SEQ -- requirements
Module: fft_seq

Interface
REQ-001 SHALL have parameter LANES, default 4, samples moved per beat (power of two, at least 1).
REQ-002 SHALL have parameter NUMSAMPLES, default 32, samples per frame (power of two, multiple of LANES).
REQ-003 SHALL have parameter NUMSTAGES, default 5, butterfly stages per frame.
REQ-004 SHALL have parameter TIMEOUT, default 255, maximum consecutive idle load cycles before error.
REQ-005 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port start, input, 1, frame request; sampled only in IDLE.
REQ-008 SHALL have port abort, input, 1, cancels the frame from any state.
REQ-009 SHALL have port ld_valid, input, 1, source offers one load beat.
REQ-010 SHALL have port ld_data, output, 1, load phase active and ready for beats.
REQ-011 SHALL have port en, output, 1, core compute enable.
REQ-012 SHALL have port stage_done, input, 1, core single-cycle pulse at the end of each stage.
REQ-013 SHALL have port stage, output, clog2(NUMSTAGES+1), count of completed stages.
REQ-014 SHALL have port output_data, output, 1, output phase active.
REQ-015 SHALL have port out_valid, output, 1, output beat available.
REQ-016 SHALL have port out_ready, input, 1, sink accepts the beat.
REQ-017 SHALL have port beat, output, clog2(NUMSAMPLES/LANES), current load or output beat index.
REQ-018 SHALL have port done, output, 1, frame computed; held from DONE through the last output beat.
REQ-019 SHALL have port error, output, 1, sticky load-timeout flag.

Function
REQ-020 SHALL implement a Moore FSM with states IDLE, LDRAM, RAMRDY, RUNNING, DONE and OUTPUT; all outputs SHALL be registered.
REQ-021 SHALL go IDLE->LDRAM on start; start in any other state SHALL be ignored.
REQ-022 In LDRAM, ld_data=1; each cycle with ld_valid=1 SHALL accept one beat and increment beat; acceptance of beat NUMSAMPLES/LANES-1 SHALL go to RAMRDY with beat=0.
REQ-023 In LDRAM, an idle-cycle counter SHALL increment on each cycle with ld_valid=0 and clear on ld_valid=1; reaching TIMEOUT SHALL set error and go to IDLE.
REQ-024 RAMRDY SHALL last exactly one cycle with ld_data=0, then go to RUNNING.
REQ-025 In RUNNING, en=1; stage SHALL increment on each stage_done; stage_done while stage equals NUMSTAGES-1 SHALL go to DONE; stage_done outside RUNNING SHALL be ignored.
REQ-026 DONE SHALL last one cycle with en=0 and done=1, then go to OUTPUT.
REQ-027 In OUTPUT, output_data=1 and out_valid=1; beat SHALL advance only on out_valid and out_ready; the final beat handshake SHALL go to IDLE and clear done, stage and beat.
REQ-028 out_valid SHALL stay asserted, with beat held, while out_ready=0.
REQ-029 abort SHALL take priority over every other transition; the next state SHALL be IDLE with all counters and outputs at reset values, except that error SHALL be retained.
REQ-030 start SHALL clear error when it launches a frame.
REQ-031 beat SHALL wrap to 0 after the last beat; counters SHALL never exceed their terminal values.

Reset
REQ-032 While rst_n=0, the state SHALL be IDLE and ld_data, en, output_data, out_valid, done, error, stage and beat SHALL all be 0, asynchronously.
REQ-033 Reset deassertion mid-frame SHALL resume only from IDLE; no partial frame SHALL continue.

Configuration
REQ-034 With macro FFT_SEQ_CONTINUOUS_EN defined, the final output beat SHALL go directly to LDRAM for the next frame without start; without it, the final output beat SHALL go to IDLE.

Verification
REQ-035 Default parameters, start, 8 ld_valid beats SHALL give RAMRDY after beat 7; 5 stage_done pulses SHALL give done=1 and stage=5; 8 out_ready beats SHALL return to IDLE.
REQ-036 ld_valid low for 255 cycles in LDRAM SHALL give error=1 and IDLE; the next start SHALL clear error.
REQ-037 out_ready alternating 0/1 in OUTPUT SHALL take 16 cycles for 8 beats, with beat stable during stalls.
REQ-038 abort in RUNNING at stage=3 SHALL give IDLE next cycle, stage=0, en=0.
REQ-039 rst_n pulsed low during OUTPUT SHALL clear all outputs immediately; start SHALL then run a full frame.
REQ-040 With FFT_SEQ_CONTINUOUS_EN defined, two back-to-back frames SHALL complete from a single start.
